// File: rtl/filter_input_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream parser from NUM_PORTS sources.
// Optional per-port packet counters are built when FILTER_ARB_PKT_COUNT_EN is defined.
module filter_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int IDX_W                = 2
) (
    input  logic                                      axi_aclk,
    input  logic                                      axi_areset,
    input  logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_PORTS*C_M_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    output logic                                      grant_valid,
    output logic [IDX_W-1:0]                          grant_idx,
    output logic [NUM_PORTS*32-1:0]                   pkt_count
);
    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;

    // Handshake rule: a beat moves when m_axis_tvalid & m_axis_tready are both high;
    // only the granted source ever sees tready, mirrored from the sink.
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] grant_nxt, last_grant, last_grant_nxt, winner;
    logic             found, pkt_done;

    // Rotating priority: the port after the last one served is searched first.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            int p;
            p = (int'(last_grant) + k) % NUM_PORTS;
            if (!found && s_axis_tvalid[p]) begin
                found  = 1'b1;
                winner = IDX_W'(p);
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == BUSY) begin
            m_axis_tdata             = s_axis_tdata[grant_idx*DW +: DW];
            m_axis_tstrb             = s_axis_tstrb[grant_idx*SW +: SW];
            m_axis_tuser             = s_axis_tuser[grant_idx*UW +: UW];
            m_axis_tvalid            = s_axis_tvalid[grant_idx];
            m_axis_tlast             = s_axis_tlast[grant_idx];
            s_axis_tready[grant_idx] = m_axis_tready;
        end
    end

    assign pkt_done    = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign grant_valid = (state == BUSY);

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_idx;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    grant_nxt = winner;
                end
            end
            BUSY: begin
                if (pkt_done) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

`ifdef FILTER_ARB_PKT_COUNT_EN
    logic [NUM_PORTS*32-1:0] cnt_q;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pkt_done && grant_idx == IDX_W'(i))
                    cnt_q[i*32 +: 32] <= cnt_q[i*32 +: 32] + 32'd1;
            end
        end
    end

    assign pkt_count = cnt_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_filter_input_arbiter.sv
// Directed + randomized bench for filter_input_arbiter; per-port beat queues form the reference.
module tb_filter_input_arbiter;
    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int SW  = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic                axi_aclk = 1'b0;
    logic                axi_areset = 1'b1;
    logic [N*DW-1:0]     s_axis_tdata = '0;
    logic [N*SW-1:0]     s_axis_tstrb = '0;
    logic [N*UW-1:0]     s_axis_tuser = '0;
    logic [N-1:0]        s_axis_tvalid = '0;
    logic [N-1:0]        s_axis_tlast = '0;
    logic [N-1:0]        s_axis_tready;
    logic [DW-1:0]       m_axis_tdata;
    logic [SW-1:0]       m_axis_tstrb;
    logic [UW-1:0]       m_axis_tuser;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tready = 1'b0;
    logic                grant_valid;
    logic [IW-1:0]       grant_idx;
    logic [N*32-1:0]     pkt_count;

    filter_input_arbiter #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(UW), .NUM_PORTS(N), .IDX_W(IW)
    ) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .pkt_count(pkt_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    beat_t       src_q[N][$];
    int          hs_cyc[$];
    int          grant_obs[$];
    logic [N-1:0] stall = '0;
    logic        m_ready = 1'b1;
    logic        prev_gv = 1'b0;
    // reference model state
    bit          m_busy = 1'b0;
    int          m_grant = 0;
    int          m_last = N - 1;
    logic [31:0] m_cnt[N];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N*32-1:0] exp_cnt();
        logic [N*32-1:0] v;
        v = '0;
`ifdef FILTER_ARB_PKT_COUNT_EN
        for (int i = 0; i < N; i++) v[i*32 +: 32] = m_cnt[i];
`endif
        return v;
    endfunction

    function automatic beat_t rand_beat(input logic last);
        beat_t b;
        for (int j = 0; j < DW / 32; j++) b.data[j*32 +: 32] = $urandom;
        b.strb = $urandom;
        for (int j = 0; j < UW / 32; j++) b.user[j*32 +: 32] = $urandom;
        b.last = last;
        return b;
    endfunction

    task automatic load_pkt(input int port, input int beats);
        for (int j = 0; j < beats; j++) src_q[port].push_back(rand_beat(j == beats - 1));
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !stall[i]) begin
                b = src_q[i][0];
                s_axis_tvalid[i]        = 1'b1;
                s_axis_tdata[i*DW +: DW] = b.data;
                s_axis_tstrb[i*SW +: SW] = b.strb;
                s_axis_tuser[i*UW +: UW] = b.user;
                s_axis_tlast[i]         = b.last;
            end else begin
                s_axis_tvalid[i]        = 1'b0;
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tstrb[i*SW +: SW] = '0;
                s_axis_tuser[i*UW +: UW] = '0;
                s_axis_tlast[i]         = 1'b0;
            end
        end
        m_axis_tready = m_ready;
    endtask

    // One clock: drive at negedge, check 1ns later, advance the model to the next posedge.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        bit           exp_mv;
        int           w;
        beat_t        b;
        drive();
        #1;
        cyc++;
        if (grant_valid && !prev_gv) grant_obs.push_back(int'(grant_idx));
        prev_gv = grant_valid;
        if (m_axis_tvalid && m_axis_tready) hs_cyc.push_back(cyc);
        chk("grant_valid", DW'(grant_valid), DW'(m_busy));
        if (m_busy) chk("grant_idx", DW'(grant_idx), DW'(m_grant));
        exp_mv = m_busy && s_axis_tvalid[m_grant];
        chk("m_tvalid", DW'(m_axis_tvalid), DW'(exp_mv));
        exp_rdy = '0;
        if (m_busy && m_ready) exp_rdy[m_grant] = 1'b1;
        chk("s_tready", DW'(s_axis_tready), DW'(exp_rdy));
        if (exp_mv) begin
            b = src_q[m_grant][0];
            chk("m_tdata", m_axis_tdata, b.data);
            chk("m_tstrb", DW'(m_axis_tstrb), DW'(b.strb));
            chk("m_tuser", DW'(m_axis_tuser), DW'(b.user));
            chk("m_tlast", DW'(m_axis_tlast), DW'(b.last));
        end else if (!m_busy) begin
            chk("m_tdata_idle", m_axis_tdata, '0);
        end
        chk("pkt_count", DW'(pkt_count), DW'(exp_cnt()));
        if (!m_busy) begin
            w = rr_pick(m_last, s_axis_tvalid);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_grant = w;
            end
        end else if (exp_mv && m_ready) begin
            b = src_q[m_grant].pop_front();
            if (b.last) begin
                m_busy = 1'b0;
                m_last = m_grant;
                m_cnt[m_grant] = m_cnt[m_grant] + 32'd1;
            end
        end
        @(posedge axi_aclk);
        @(negedge axi_aclk);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int  n;
        bit  done;
        n = 0;
        while (!(all_empty() && !m_busy) && n < budget) begin
            cycle();
            n++;
        end
        cycle();
        done = all_empty() && !m_busy;
        tests++;
        assert (done) else begin
            fails++;
            $error("FAIL %s_timeout observed=busy expected=idle within %0d cycles", tag, budget);
        end
    endtask

    task automatic run_until_left(input int port, input int left, input int budget);
        int n;
        n = 0;
        while (src_q[port].size() > left && n < budget) begin
            cycle();
            n++;
        end
        chk("queue_progress", DW'(src_q[port].size()), DW'(left));
    endtask

    // Assert reset where the caller stands; outputs must drop at once, then release on a negedge.
    task automatic do_reset();
        axi_areset = 1'b1;
        #1;
        chk("rst_grant_valid", DW'(grant_valid), '0);
        chk("rst_m_tvalid", DW'(m_axis_tvalid), '0);
        chk("rst_s_tready", DW'(s_axis_tready), '0);
        chk("rst_m_tdata", m_axis_tdata, '0);
        chk("rst_pkt_count", DW'(pkt_count), '0);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            m_cnt[i] = '0;
        end
        stall   = '0;
        m_busy  = 1'b0;
        m_grant = 0;
        m_last  = N - 1;
        prev_gv = 1'b0;
        drive();
        @(negedge axi_aclk);
        axi_areset = 1'b0;
    endtask

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int pat[4] = '{1, 0, 0, 1};
        int h0;
`ifdef FILTER_ARB_PKT_COUNT_EN
        logic [N*32-1:0] fv;
`endif
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
        @(negedge axi_aclk);
        do_reset();
        cycle();

        // 3-beat packet on port 1
        m_ready = 1'b1;
        h0 = hs_cyc.size();
        load_pkt(1, 3);
        run_until_idle("p1_pkt", 20);
        chk("p1_beats", DW'(hs_cyc.size() - h0), DW'(3));

        // all ports contend with 2-beat packets
        do_reset();
        grant_obs.delete();
        h0 = hs_cyc.size();
        load_pkt(0, 2); load_pkt(1, 2); load_pkt(2, 2); load_pkt(3, 2); load_pkt(0, 2);
        run_until_idle("rr", 60);
        chk("rr_grants", DW'(grant_obs.size()), DW'(5));
        for (int i = 0; i < 5 && i < grant_obs.size(); i++) chk("rr_order", DW'(grant_obs[i]), DW'(exp_seq[i]));
        chk("rr_span", DW'(hs_cyc[hs_cyc.size() - 1] - hs_cyc[h0]), DW'(13));

        // port 2 under sink backpressure
        h0 = hs_cyc.size();
        load_pkt(2, 4);
        for (int k = 0; k < 40 && !(all_empty() && !m_busy); k++) begin
            m_ready = pat[k % 4][0];
            cycle();
        end
        m_ready = 1'b1;
        run_until_idle("bp", 10);
        chk("bp_beats", DW'(hs_cyc.size() - h0), DW'(4));

        // port 0 source stall while port 3 waits
        load_pkt(0, 4);
        run_until_left(0, 2, 20);
        stall[0] = 1'b1;
        load_pkt(3, 2);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_grant", DW'(grant_idx), DW'(0));
            chk("stall_tvalid", DW'(m_axis_tvalid), '0);
        end
        stall[0] = 1'b0;
        grant_obs.delete();
        run_until_idle("stall", 30);
        chk("stall_then_p3", DW'(grant_obs.size() > 0 ? grant_obs[grant_obs.size() - 1] : -1), DW'(3));

        // reset in the middle of a port-1 packet
        load_pkt(1, 3);
        run_until_left(1, 2, 20);
        drive();
        #2;
        do_reset();
        grant_obs.delete();
        load_pkt(1, 1); load_pkt(0, 1);
        run_until_idle("post_rst", 20);
        chk("post_rst_first", DW'(grant_obs.size() > 0 ? grant_obs[0] : -1), DW'(0));

        // back-to-back single-beat packets on port 3
`ifdef FILTER_ARB_PKT_COUNT_EN
        fv = exp_cnt();
        fv[3*32 +: 32] = 32'hFFFF_FFFF;
        force dut.cnt_q = fv;
        #1;
        release dut.cnt_q;
        m_cnt[3] = 32'hFFFF_FFFF;
`endif
        h0 = hs_cyc.size();
        for (int k = 0; k < 4; k++) load_pkt(3, 1);
        run_until_idle("single", 20);
        chk("single_beats", DW'(hs_cyc.size() - h0), DW'(4));
        for (int k = h0 + 1; k < hs_cyc.size(); k++) chk("single_gap", DW'(hs_cyc[k] - hs_cyc[k-1]), DW'(2));
`ifdef FILTER_ARB_PKT_COUNT_EN
        chk("wrap_count", DW'(pkt_count[3*32 +: 32]), DW'(32'd3));
`endif

        // randomized traffic, ready and source stalls
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, N - 1);
                if (src_q[p].size() < 8) load_pkt(p, $urandom_range(1, 4));
            end
            m_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) stall[i] = ($urandom_range(0, 5) == 0);
            cycle();
        end
        stall   = '0;
        m_ready = 1'b1;
        run_until_idle("random", 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_input_arbiter.md
Name: filter_input_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single header parser / filter datapath between NUM_PORTS upstream AXI-Stream sources.
- Sits directly in front of the parser. Grants one source for one whole packet (first beat through tlast), so the parser's two-beat header extraction never sees interleaved packets.
- Data, strobe, tuser and tlast pass through unmodified.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, data width of master and each slave.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width of master and each slave.
- NUM_PORTS, 4, number of slave streams; legal range 2..8.
- IDX_W, 2, grant index width; must equal ceil(log2(NUM_PORTS)).

Ports:
- axi_aclk  in  1  single clock, all logic rising-edge.
- axi_areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_PORTS*C_M_AXIS_DATA_WIDTH  slave data; port i occupies slice i.
- s_axis_tstrb  in  NUM_PORTS*C_M_AXIS_DATA_WIDTH/8  slave strobes.
- s_axis_tuser  in  NUM_PORTS*C_M_AXIS_TUSER_WIDTH  slave tuser.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  to parser.
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  to parser.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  to parser.
- m_axis_tvalid  out  1  to parser.
- m_axis_tlast  out  1  to parser.
- m_axis_tready  in  1  from parser.
- grant_valid  out  1  high while a packet is granted.
- grant_idx  out  IDX_W  index of the granted port.
- pkt_count  out  NUM_PORTS*32  per-port forwarded-packet counters (see Optional Feature).

Behaviour:
- Reset (async assert, release on clock edge):
  - state=IDLE, grant_idx=0, grant_valid=0, last_grant=NUM_PORTS-1 (port 0 has highest priority first).
  - All s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tstrb/tuser/tlast=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - Search s_axis_tvalid starting at last_grant+1, wrapping modulo NUM_PORTS.
  - The first set bit wins; register grant_idx=winner, grant_valid=1, go to BUSY.
  - No valid bits: stay in IDLE.
  - No tready is asserted in IDLE, so the arbitration decision costs 1 bubble cycle.
- BUSY:
  - m_axis_* = slice grant_idx of s_axis_* (combinational mux).
  - s_axis_tready[grant_idx]=m_axis_tready; all other readies are 0.
  - A handshake is m_axis_tvalid & m_axis_tready.
  - Handshake with tlast=1: last_grant<=grant_idx, grant_valid<=0, go to IDLE.
- Source stalls mid-packet (tvalid=0): grant held indefinitely; m_axis_tvalid=0; no re-arbitration.
- Sink backpressure (m_axis_tready=0): granted source sees tready=0; data must stay stable because it is muxed directly from the source.
- Single-beat packet (tlast on first beat): one handshake, then IDLE.
- Minimum throughput: 1 idle cycle between packets.
- Simultaneous requests: strict rotating order; with all ports always valid, grants go 0,1,2,3,0,...
- Non-granted valids are ignored but remain pending; sources must hold tvalid per AXI-S rules.
- Reset asserted mid-packet: outputs drop to reset values immediately (async). The partial packet is abandoned; recovery is the parser's responsibility.
- grant_idx is held unchanged in IDLE; it is meaningful only when grant_valid=1.

Optional Feature:
- Macro: FILTER_ARB_PKT_COUNT_EN.
- Defined:
  - pkt_count slice i is a 32-bit counter, reset to 0.
  - Increments by 1 on each tlast handshake from port i.
  - Wraps 0xFFFFFFFF to 0.
  - Registered; visible the cycle after the tlast handshake.
- Undefined: pkt_count tied to 0; no counter flops are inferred.

Test Plan:
- Reset then port 1 sends a 3-beat packet, m_axis_tready=1.
  - grant_valid=1 and grant_idx=1 one cycle after tvalid.
  - 3 output beats, identical data.
  - IDLE on the cycle after tlast; pkt_count[1]=1 with macro.
- Ports 0–3 all hold 2-beat packets continuously.
  - Grant sequence 0,1,2,3,0.
  - Each packet is contiguous on m_axis with no interleaving.
  - One idle cycle between packets.
- Port 2 granted, m_axis_tready toggles 1,0,0,1 during a 4-beat packet.
  - Exactly 4 handshakes with correct data.
  - s_axis_tready[0,1,3]=0 throughout.
- Port 0 granted, port 0 tvalid drops for 5 cycles mid-packet while port 3 valid.
  - Grant stays on 0; m_axis_tvalid=0 during the gap.
  - Port 3 granted only after port 0 tlast.
- Assert axi_areset during beat 2 of a port-1 packet.
  - m_axis_tvalid=0, all s_axis_tready=0, grant_valid=0, pkt_count=0 immediately.
  - After release with ports 1 and 0 both valid, port 0 is granted first.
- Single-beat packets on port 3 only, back-to-back.
  - One beat every 2 cycles, grant_idx=3 each time.
  - With macro: pkt_count[3] preloaded to 0xFFFFFFFF via force, wraps to 0.
